frog_ctrl: RTL and testbench

- Frog movement and life controller. Produces the frog_x / frog_y / frog_size values that the frog sprite renderer consumes each frame.
- Turns button presses into animated 32-pixel hops, clamped to the playfield, on a per-frame tick.
- Handles collision death, respawn, lives and goal scoring.
- Sits between the button inputs / collision logic and the pixel renderers.

---
 rtl/frog_ctrl_if.sv | 27 ++
 rtl/frog_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_frog_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/frog_ctrl_if.sv
// Signal bundle between the frog controller, its button/collision sources and the sprite renderer.
interface frog_ctrl_if;
   logic       frame_tick;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       hit;
   logic [9:0] frog_x;
   logic [9:0] frog_y;
   logic [9:0] frog_size;
   logic       hopping;
   logic       dead;
   logic       game_over;
   logic [1:0] lives;
   logic [7:0] score;

   modport master (
      output frame_tick, btn_up, btn_down, btn_left, btn_right, hit,
      input  frog_x, frog_y, frog_size, hopping, dead, game_over, lives, score
   );

   modport slave (
      input  frame_tick, btn_up, btn_down, btn_left, btn_right, hit,
      output frog_x, frog_y, frog_size, hopping, dead, game_over, lives, score
   );
endinterface

// File: rtl/frog_ctrl.sv
// Frog movement/life controller: animated 32 px hops, death/respawn, lives and goal scoring.
// Optional macro FROG_WRAP_EN: horizontal hops past a bound wrap to the opposite bound.
module frog_ctrl #(
   parameter int unsigned FROG_SIZE    = 32,
   parameter int unsigned STEP         = 32,
   parameter int unsigned HOP_FRAMES   = 4,
   parameter int unsigned START_X      = 304,
   parameter int unsigned START_Y      = 448,
   parameter int unsigned MIN_X        = 0,
   parameter int unsigned MAX_X        = 608,
   parameter int unsigned MIN_Y        = 0,
   parameter int unsigned MAX_Y        = 448,
   parameter int unsigned DEATH_FRAMES = 30,
   parameter int unsigned LIVES        = 3
) (
   input  logic        clk,
   input  logic        reset,
   frog_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOP  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;
   localparam logic [1:0] S_OVER = 2'd3;

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_DOWN  = 2'd1;
   localparam logic [1:0] D_LEFT  = 2'd2;
   localparam logic [1:0] D_RIGHT = 2'd3;

   localparam int unsigned HC_W = $clog2(HOP_FRAMES + 1);
   localparam int unsigned DC_W = $clog2(DEATH_FRAMES + 1);

   localparam logic [9:0]        MOVE      = 10'(STEP / HOP_FRAMES);
   localparam logic signed [11:0] STEP_S   = 12'(STEP);
   localparam logic signed [11:0] MIN_X_S  = 12'(MIN_X);
   localparam logic signed [11:0] MAX_X_S  = 12'(MAX_X);
   localparam logic signed [11:0] MIN_Y_S  = 12'(MIN_Y);
   localparam logic signed [11:0] MAX_Y_S  = 12'(MAX_Y);

   logic [1:0]      state;
   logic [9:0]      x_q, y_q;
   logic [1:0]      lives_q;
   logic [7:0]      score_q;
   logic [3:0]      btn_q, pend_q;
   logic [1:0]      dir_q;
   logic [HC_W-1:0] hop_cnt_q;
   logic [DC_W-1:0] death_cnt_q;
   logic            wrap_q;

   logic [3:0]        btn_now, btn_rise, req;
   logic [1:0]        sel_dir;
   logic              sel_valid;
   logic signed [11:0] cur_x_s, cur_y_s, tgt_x, tgt_y;
   logic              x_ok, y_ok, wrap_hop;
   logic [9:0]        x_move, y_move;
   logic [1:0]        lives_dec;
   logic [7:0]        score_inc;

   // Bit order {up, down, left, right} matches the direction priority.
   assign btn_now  = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
   assign btn_rise = btn_now & ~btn_q;
   assign req      = pend_q | btn_rise;
   assign cur_x_s  = $signed({2'b00, x_q});
   assign cur_y_s  = $signed({2'b00, y_q});

   assign lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
   assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;

   always_comb begin
      sel_valid = 1'b1;
      sel_dir   = D_UP;
      if (req[3])      sel_dir = D_UP;
      else if (req[2]) sel_dir = D_DOWN;
      else if (req[1]) sel_dir = D_LEFT;
      else if (req[0]) sel_dir = D_RIGHT;
      else             sel_valid = 1'b0;
   end

   // Full hop target is bounds-checked up front so the 8 px steps never leave range.
   always_comb begin
      tgt_x = cur_x_s;
      tgt_y = cur_y_s;
      case (sel_dir)
         D_UP:    tgt_y = cur_y_s - STEP_S;
         D_DOWN:  tgt_y = cur_y_s + STEP_S;
         D_LEFT:  tgt_x = cur_x_s - STEP_S;
         default: tgt_x = cur_x_s + STEP_S;
      endcase
      x_ok = (tgt_x >= MIN_X_S) && (tgt_x <= MAX_X_S);
      y_ok = (tgt_y >= MIN_Y_S) && (tgt_y <= MAX_Y_S);
`ifdef FROG_WRAP_EN
      wrap_hop = sel_valid && sel_dir[1] && !x_ok;
`else
      wrap_hop = 1'b0;
`endif
   end

   always_comb begin
      x_move = x_q;
      y_move = y_q;
      case (dir_q)
         D_UP:    y_move = y_q - MOVE;
         D_DOWN:  y_move = y_q + MOVE;
         D_LEFT:  x_move = x_q - MOVE;
         default: x_move = x_q + MOVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         x_q         <= 10'(START_X);
         y_q         <= 10'(START_Y);
         lives_q     <= 2'(LIVES);
         score_q     <= '0;
         btn_q       <= '0;
         pend_q      <= '0;
         dir_q       <= D_UP;
         hop_cnt_q   <= '0;
         death_cnt_q <= '0;
         wrap_q      <= 1'b0;
      end else begin
         btn_q <= btn_now;
         case (state)
            S_IDLE: begin
               pend_q <= pend_q | btn_rise;
               if (bus.frame_tick) begin
                  pend_q <= '0;
                  if (bus.hit) begin
                     state       <= S_DEAD;
                     lives_q     <= lives_dec;
                     death_cnt_q <= '0;
                  end else if (sel_valid && ((x_ok && y_ok) || wrap_hop)) begin
                     state     <= S_HOP;
                     dir_q     <= sel_dir;
                     hop_cnt_q <= '0;
                     wrap_q    <= wrap_hop;
                  end
               end
            end
            S_HOP: begin
               pend_q <= '0;
               if (bus.frame_tick) begin
                  if (bus.hit) begin
                     state       <= S_DEAD;
                     lives_q     <= lives_dec;
                     death_cnt_q <= '0;
                     wrap_q      <= 1'b0;
                  end else if (wrap_q) begin
                     x_q    <= (dir_q == D_LEFT) ? 10'(MAX_X) : 10'(MIN_X);
                     wrap_q <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     x_q       <= x_move;
                     y_q       <= y_move;
                     hop_cnt_q <= hop_cnt_q + 1'b1;
                     if (hop_cnt_q == HC_W'(HOP_FRAMES - 1)) begin
                        state <= S_IDLE;
                        if (y_move == 10'(MIN_Y)) begin
                           score_q <= score_inc;
                           x_q     <= 10'(START_X);
                           y_q     <= 10'(START_Y);
                        end
                     end
                  end
               end
            end
            S_DEAD: begin
               pend_q <= '0;
               if (bus.frame_tick) begin
                  if (death_cnt_q == DC_W'(DEATH_FRAMES - 1)) begin
                     if (lives_q != 2'd0) begin
                        state <= S_IDLE;
                        x_q   <= 10'(START_X);
                        y_q   <= 10'(START_Y);
                     end else begin
                        state <= S_OVER;
                     end
                  end else begin
                     death_cnt_q <= death_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               pend_q <= '0;
               if (btn_rise[3]) begin
                  state   <= S_IDLE;
                  lives_q <= 2'(LIVES);
                  score_q <= '0;
                  x_q     <= 10'(START_X);
                  y_q     <= 10'(START_Y);
               end
            end
         endcase
      end
   end

   assign bus.frog_x    = x_q;
   assign bus.frog_y    = y_q;
   assign bus.frog_size = 10'(FROG_SIZE);
   assign bus.hopping   = (state == S_HOP);
   assign bus.dead      = (state == S_DEAD);
   assign bus.game_over = (state == S_OVER);
   assign bus.lives     = lives_q;
   assign bus.score     = score_q;

endmodule

// File: tb/tb_frog_ctrl.sv
// Self-checking bench for frog_ctrl: vector table, directed corner sequences, randomized run vs reference model.
module tb_frog_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   frog_ctrl_if bus();

   frog_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

   // Reference model: position, lives, score and remaining-frame countdowns.
   typedef enum int {M_IDLE, M_HOP, M_DEAD, M_OVER} mode_t;
   mode_t      m_mode;
   int         m_x, m_y, m_lives, m_score;
   int         m_dx, m_dy, m_hop_left, m_death_left, m_wrap_x;
   logic [3:0] m_prev, m_pend;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic model_die();
      m_mode       = M_DEAD;
      m_lives      = (m_lives > 0) ? m_lives - 1 : 0;
      m_death_left = 30;
      m_wrap_x     = -1;
   endtask

   task automatic model_clk(input logic rst, input logic tick, input logic [3:0] b, input logic h);
      logic [3:0] rise;
      int tx, ty;
      rise   = b & ~m_prev;
      m_prev = b;
      if (rst) begin
         m_mode = M_IDLE; m_x = 304; m_y = 448; m_lives = 3; m_score = 0;
         m_prev = '0; m_pend = '0; m_wrap_x = -1; m_hop_left = 0;
         return;
      end
      case (m_mode)
         M_IDLE: begin
            m_pend = m_pend | rise;
            if (tick) begin
               if (h) model_die();
               else if (m_pend != 0) begin
                  m_dx = 0; m_dy = 0;
                  if (m_pend[3])      m_dy = -8;
                  else if (m_pend[2]) m_dy = 8;
                  else if (m_pend[1]) m_dx = -8;
                  else                m_dx = 8;
                  tx = m_x + 4 * m_dx;
                  ty = m_y + 4 * m_dy;
                  if (tx >= 0 && tx <= 608 && ty >= 0 && ty <= 448) begin
                     m_mode = M_HOP; m_hop_left = 4;
                  end
`ifdef FROG_WRAP_EN
                  else if (m_dx != 0) begin
                     m_mode = M_HOP; m_hop_left = 1;
                     m_wrap_x = (m_dx < 0) ? 608 : 0;
                  end
`endif
               end
               m_pend = '0;
            end
         end
         M_HOP: begin
            m_pend = '0;
            if (tick) begin
               if (h) model_die();
               else if (m_wrap_x >= 0) begin
                  m_x = m_wrap_x; m_wrap_x = -1; m_mode = M_IDLE;
               end else begin
                  m_x += m_dx; m_y += m_dy; m_hop_left--;
                  if (m_hop_left == 0) begin
                     m_mode = M_IDLE;
                     if (m_y == 0) begin
                        m_score = (m_score < 255) ? m_score + 1 : 255;
                        m_x = 304; m_y = 448;
                     end
                  end
               end
            end
         end
         M_DEAD: begin
            m_pend = '0;
            if (tick) begin
               m_death_left--;
               if (m_death_left == 0) begin
                  if (m_lives > 0) begin m_mode = M_IDLE; m_x = 304; m_y = 448; end
                  else m_mode = M_OVER;
               end
            end
         end
         default: begin
            m_pend = '0;
            if (rise[3]) begin
               m_mode = M_IDLE; m_lives = 3; m_score = 0; m_x = 304; m_y = 448;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      check("frog_x",    int'(bus.frog_x),    m_x);
      check("frog_y",    int'(bus.frog_y),    m_y);
      check("frog_size", int'(bus.frog_size), 32);
      check("hopping",   int'(bus.hopping),   int'(m_mode == M_HOP));
      check("dead",      int'(bus.dead),      int'(m_mode == M_DEAD));
      check("game_over", int'(bus.game_over), int'(m_mode == M_OVER));
      check("lives",     int'(bus.lives),     m_lives);
      check("score",     int'(bus.score),     m_score);
   endtask

   task automatic step(input logic rst, input logic tick, input logic [3:0] b, input logic h);
      reset          = rst;
      bus.frame_tick = tick;
      {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = b;
      bus.hit        = h;
      @(posedge clk);
      model_clk(rst, tick, b, h);
      #1;
      compare_all();
   endtask

   task automatic hop(input logic [3:0] m);
      step(1'b0, 1'b0, m, 1'b0);
      step(1'b0, 1'b0, 4'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 4'b0, 1'b0);
   endtask

   typedef struct {
      logic       rst;
      logic       tick;
      logic [3:0] btn;
      logic       hit;
      int         ex;
      int         ey;
      logic       ehop;
      int         elives;
      int         escore;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [3:0] rb;
      logic       rt;

      vecs[0]  = '{1'b1, 1'b0, 4'b0,        1'b0, 304, 448, 1'b0, 3, 0};
      vecs[1]  = '{1'b0, 1'b0, B_UP,        1'b0, 304, 448, 1'b0, 3, 0};
      vecs[2]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 448, 1'b1, 3, 0};
      vecs[3]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 440, 1'b1, 3, 0};
      vecs[4]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 432, 1'b1, 3, 0};
      vecs[5]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 424, 1'b1, 3, 0};
      vecs[6]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 416, 1'b0, 3, 0};
      vecs[7]  = '{1'b0, 1'b0, B_UP | B_LT, 1'b0, 304, 416, 1'b0, 3, 0};
      vecs[8]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 416, 1'b1, 3, 0};
      vecs[9]  = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 408, 1'b1, 3, 0};
      vecs[10] = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 400, 1'b1, 3, 0};
      vecs[11] = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 392, 1'b1, 3, 0};
      vecs[12] = '{1'b0, 1'b1, 4'b0,        1'b0, 304, 384, 1'b0, 3, 0};

      m_prev = '0;
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].tick, vecs[i].btn, vecs[i].hit);
         check($sformatf("vec%0d_x", i),     int'(bus.frog_x),  vecs[i].ex);
         check($sformatf("vec%0d_y", i),     int'(bus.frog_y),  vecs[i].ey);
         check($sformatf("vec%0d_hop", i),   int'(bus.hopping), int'(vecs[i].ehop));
         check($sformatf("vec%0d_lives", i), int'(bus.lives),   vecs[i].elives);
         check($sformatf("vec%0d_score", i), int'(bus.score),   vecs[i].escore);
      end

      // Left bound: 304 -> 16 in nine hops, then a tenth left hop is out of range.
      step(1'b1, 1'b0, 4'b0, 1'b0);
      repeat (9) hop(B_LT);
      check("left_chain_x", int'(bus.frog_x), 16);
      step(1'b0, 1'b0, B_LT, 1'b0);
      step(1'b0, 1'b0, 4'b0, 1'b0);
      step(1'b0, 1'b1, 4'b0, 1'b0);
`ifdef FROG_WRAP_EN
      check("wrap_hopping", int'(bus.hopping), 1);
      step(1'b0, 1'b1, 4'b0, 1'b0);
      check("wrap_x", int'(bus.frog_x), 608);
`else
      check("bound_hopping", int'(bus.hopping), 0);
      check("bound_x", int'(bus.frog_x), 16);
`endif

      // Death in IDLE, 30-tick wait, respawn.
      step(1'b0, 1'b1, 4'b0, 1'b1);
      check("death_dead", int'(bus.dead), 1);
      check("death_lives", int'(bus.lives), 2);
      repeat (29) step(1'b0, 1'b1, 4'b0, 1'b0);
      check("death_29_dead", int'(bus.dead), 1);
      step(1'b0, 1'b1, 4'b0, 1'b0);
      check("respawn_dead", int'(bus.dead), 0);
      check("respawn_x", int'(bus.frog_x), 304);
      check("respawn_y", int'(bus.frog_y), 448);

      for (int d = 0; d < 2; d++) begin
         step(1'b0, 1'b1, 4'b0, 1'b1);
         repeat (30) step(1'b0, 1'b1, 4'b0, 1'b0);
      end
      check("over_flag", int'(bus.game_over), 1);
      check("over_lives", int'(bus.lives), 0);
      step(1'b0, 1'b1, 4'b0, 1'b1);
      check("over_hit_ignored", int'(bus.game_over), 1);
      step(1'b0, 1'b0, B_UP, 1'b0);
      check("restart_over", int'(bus.game_over), 0);
      check("restart_lives", int'(bus.lives), 3);
      check("restart_score", int'(bus.score), 0);
      step(1'b0, 1'b0, 4'b0, 1'b0);

      // Goal: thirteen hops to y=32, fourteenth scores.
      step(1'b1, 1'b0, 4'b0, 1'b0);
      repeat (13) hop(B_UP);
      check("chain_y", int'(bus.frog_y), 32);
      hop(B_UP);
      check("goal_score", int'(bus.score), 1);
      check("goal_x", int'(bus.frog_x), 304);
      check("goal_y", int'(bus.frog_y), 448);

      // Same goal hop but hit on its last tick.
      step(1'b1, 1'b0, 4'b0, 1'b0);
      repeat (13) hop(B_UP);
      step(1'b0, 1'b0, B_UP, 1'b0);
      step(1'b0, 1'b0, 4'b0, 1'b0);
      repeat (4) step(1'b0, 1'b1, 4'b0, 1'b0);
      step(1'b0, 1'b1, 4'b0, 1'b1);
      check("goalhit_dead", int'(bus.dead), 1);
      check("goalhit_score", int'(bus.score), 0);
      check("goalhit_y", int'(bus.frog_y), 8);
      check("goalhit_lives", int'(bus.lives), 2);

      // Reset on the second tick of a hop.
      step(1'b1, 1'b0, 4'b0, 1'b0);
      step(1'b0, 1'b0, B_UP, 1'b0);
      step(1'b0, 1'b0, 4'b0, 1'b0);
      step(1'b0, 1'b1, 4'b0, 1'b0);
      step(1'b0, 1'b1, 4'b0, 1'b0);
      check("midhop_y", int'(bus.frog_y), 440);
      step(1'b1, 1'b1, 4'b0, 1'b0);
      check("midrst_y", int'(bus.frog_y), 448);
      check("midrst_hop", int'(bus.hopping), 0);
      check("midrst_lives", int'(bus.lives), 3);

      // Randomized run; buttons only change off frame_tick cycles.
      step(1'b1, 1'b0, 4'b0, 1'b0);
      rb = '0;
      for (int c = 0; c < 4000; c++) begin
         rt = ($urandom_range(0, 3) == 0);
         if (!rt && $urandom_range(0, 2) == 0) rb = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 999) == 0), rt, rb, rt && ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
